// File: rtl/xff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xff_pkg                                                         |
// | Brief    : Shared types and default sizes for the xff_using_t block.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package xff_pkg;

  typedef enum logic [1:0] {
    XFF_SR = 2'd0,
    XFF_JK = 2'd1,
    XFF_D  = 2'd2,
    XFF_T  = 2'd3
  } xff_mode_e;

  localparam int XFF_WIDTH = 4;
  localparam int XFF_CNT_W = 8;

endpackage : xff_pkg
`default_nettype wire

// File: rtl/xff_using_t_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xff_using_t_if                                                  |
// | Brief    : Control/status bundle of the flip-flop conversion bank.         |
// |            illegal_cnt exists only when XFF_ILLEGAL_CNT_EN is defined.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface xff_using_t_if
  import xff_pkg::*;
#(
  parameter int WIDTH = XFF_WIDTH,
  parameter int CNT_W = XFF_CNT_W
);

  logic             en;
  xff_mode_e        mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_flag;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             illegal;
  logic             illegal_sticky;
`ifdef XFF_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt;
`endif

  modport master (
    output en, mode, a, b, clr_flag,
`ifdef XFF_ILLEGAL_CNT_EN
    input  illegal_cnt,
`endif
    input  q, q_bar, illegal, illegal_sticky
  );

  modport slave (
    input  en, mode, a, b, clr_flag,
`ifdef XFF_ILLEGAL_CNT_EN
    output illegal_cnt,
`endif
    output q, q_bar, illegal, illegal_sticky
  );

endinterface : xff_using_t_if
`default_nettype wire

// File: rtl/xff_using_t_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t_ff_core                                                       |
// | Brief    : Single toggle flip-flop, synchronous active-low reset.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module t_ff_core (
  input  wire  clk,
  input  wire  reset,
  input  wire  t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule : t_ff_core
`default_nettype wire

// File: rtl/xff_using_t.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xff_using_t                                                     |
// | Brief    : SR/JK/D/T register bank built on T-flip-flop cores, with        |
// |            illegal-SR detection. Optional counter: XFF_ILLEGAL_CNT_EN.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module xff_using_t
  import xff_pkg::*;
#(
  parameter int WIDTH = XFF_WIDTH,
  parameter int CNT_W = XFF_CNT_W
) (
  input wire           clk,
  input wire           reset,
  xff_using_t_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_en;
  logic             ill_now;
  logic             illegal;
  logic             illegal_sticky;

  // S=R=1 must hold the bit, so those bits are masked out of the toggle enable.
  always_comb begin
    t = '0;
    unique case (bus.mode)
      XFF_SR:  t = ((bus.a & ~q) | (bus.b & q)) & ~(bus.a & bus.b);
      XFF_JK:  t = (bus.a & ~q) | (bus.b & q);
      XFF_D:   t = bus.a ^ q;
      default: t = bus.a;
    endcase
  end

  assign t_en = t & {WIDTH{bus.en}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_core u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_en[i]),
      .q     (q[i])
    );
  end

  // Reset gating is implicit: every flag register below clears while reset=0.
  assign ill_now = bus.en & (bus.mode == XFF_SR) & (|(bus.a & bus.b));

  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal        <= 1'b0;
      illegal_sticky <= 1'b0;
    end else begin
      illegal        <= ill_now;
      illegal_sticky <= ill_now | (illegal_sticky & ~bus.clr_flag);
    end
  end

`ifdef XFF_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_cnt <= '0;
    end else if (ill_now) begin
      if (illegal_cnt != {CNT_W{1'b1}}) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end else if (bus.clr_flag) begin
      illegal_cnt <= '0;
    end
  end

  assign bus.illegal_cnt = illegal_cnt;
`endif

  assign bus.q              = q;
  assign bus.q_bar          = ~q;
  assign bus.illegal        = illegal;
  assign bus.illegal_sticky = illegal_sticky;

endmodule : xff_using_t
`default_nettype wire

// File: tb/tb_xff_using_t.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xff_using_t                                                  |
// | Brief    : Directed self-checking bench for xff_using_t.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_xff_using_t;
  import xff_pkg::*;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr;
    logic [3:0] eq;
    logic       eill;
    logic       estk;
    logic [7:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  xff_using_t_if #(.WIDTH(4), .CNT_W(8)) bus ();

  xff_using_t #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef XFF_ILLEGAL_CNT_EN
  // Narrow-counter copy that mirrors the main stimulus, for saturation checks.
  xff_using_t_if #(.WIDTH(4), .CNT_W(2)) sat_bus ();

  assign sat_bus.en       = bus.en;
  assign sat_bus.mode     = bus.mode;
  assign sat_bus.a        = bus.a;
  assign sat_bus.b        = bus.b;
  assign sat_bus.clr_flag = bus.clr_flag;

  xff_using_t #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus.slave)
  );
`endif

  task automatic drive(input vec_t v);
    reset        = v.rst_n;
    bus.en       = v.en;
    bus.mode     = xff_mode_e'(v.mode);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.clr_flag = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[2] = '{
      '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0},
      '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      n_checks++;
      if ({bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky} !== {v[i].eq, ~v[i].eq, v[i].eill, v[i].estk}) begin
        n_fail++;
        $display("FAIL reset[%0d] got q=%b qb=%b ill=%b stk=%b exp q=%b qb=%b ill=%b stk=%b", i,
                 bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky, v[i].eq, ~v[i].eq, v[i].eill, v[i].estk);
      end
`ifdef XFF_ILLEGAL_CNT_EN
      n_checks++;
      if (bus.illegal_cnt !== v[i].ecnt) begin
        n_fail++;
        $display("FAIL reset_cnt[%0d] got %0d exp %0d", i, bus.illegal_cnt, v[i].ecnt);
      end
`endif
    end
  endtask

  task automatic test_modes();
    vec_t v[11] = '{
      // SR: set, reset, then S=R=1 on bit0 holds and flags
      '{1'b1, 1'b1, 2'd0, 4'hA, 4'h0, 1'b0, 4'hA, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h8, 1'b0, 4'h2, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b1, 8'd1},
      // JK: J=K=1 toggles twice
      '{1'b1, 1'b1, 2'd1, 4'hF, 4'hF, 1'b0, 4'hD, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd1, 4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 1'b1, 8'd1},
      // D with b ignored
      '{1'b1, 1'b1, 2'd2, 4'h6, 4'hF, 1'b0, 4'h6, 1'b0, 1'b1, 8'd1},
      // T, then en=0 holds
      '{1'b1, 1'b1, 2'd3, 4'h3, 4'h0, 1'b0, 4'h5, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 2'd3, 4'hF, 4'h0, 1'b0, 4'h5, 1'b0, 1'b1, 8'd1},
      // JK with a&b set is not illegal: bit0 (q=1) toggles via K
      '{1'b1, 1'b1, 2'd1, 4'h1, 4'h1, 1'b0, 4'h4, 1'b0, 1'b1, 8'd1},
      // T toggles all bits
      '{1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 4'hB, 1'b0, 1'b1, 8'd1}
    };
    foreach (v[i]) begin
      drive(v[i]);
      n_checks++;
      if ({bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky} !== {v[i].eq, ~v[i].eq, v[i].eill, v[i].estk}) begin
        n_fail++;
        $display("FAIL modes[%0d] got q=%b qb=%b ill=%b stk=%b exp q=%b qb=%b ill=%b stk=%b", i,
                 bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky, v[i].eq, ~v[i].eq, v[i].eill, v[i].estk);
      end
`ifdef XFF_ILLEGAL_CNT_EN
      n_checks++;
      if (bus.illegal_cnt !== v[i].ecnt) begin
        n_fail++;
        $display("FAIL modes_cnt[%0d] got %0d exp %0d", i, bus.illegal_cnt, v[i].ecnt);
      end
`endif
    end
  endtask

  task automatic test_flags();
    // Starts from q=1011, sticky=1, cnt=1.
    vec_t v[10] = '{
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd0, 4'h4, 4'h4, 1'b0, 4'hB, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd0, 4'h4, 4'h4, 1'b0, 4'hB, 1'b1, 1'b1, 8'd2},
      '{1'b1, 1'b1, 2'd0, 4'h4, 4'h4, 1'b0, 4'hB, 1'b1, 1'b1, 8'd3},
      // clear together with an illegal cycle: set and increment win
      '{1'b1, 1'b1, 2'd0, 4'h4, 4'h4, 1'b1, 4'hB, 1'b1, 1'b1, 8'd4},
      // en=0 with S=R=1: pulse drops, sticky and count hold
      '{1'b1, 1'b0, 2'd0, 4'h4, 4'h4, 1'b0, 4'hB, 1'b0, 1'b1, 8'd4},
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0, 8'd0},
      // independent bits: bit1 illegal holds, bit2 sets, bit3 resets
      '{1'b1, 1'b1, 2'd0, 4'h6, 4'hA, 1'b0, 4'h7, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 4'h7, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0, 8'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      n_checks++;
      if ({bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky} !== {v[i].eq, ~v[i].eq, v[i].eill, v[i].estk}) begin
        n_fail++;
        $display("FAIL flags[%0d] got q=%b qb=%b ill=%b stk=%b exp q=%b qb=%b ill=%b stk=%b", i,
                 bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky, v[i].eq, ~v[i].eq, v[i].eill, v[i].estk);
      end
`ifdef XFF_ILLEGAL_CNT_EN
      n_checks++;
      if (bus.illegal_cnt !== v[i].ecnt) begin
        n_fail++;
        $display("FAIL flags_cnt[%0d] got %0d exp %0d", i, bus.illegal_cnt, v[i].ecnt);
      end
`endif
    end
  endtask

  task automatic test_saturation();
    vec_t v[6] = '{
      '{1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd1},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd2},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd3},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd4},
      '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd5}
    };
    foreach (v[i]) begin
      drive(v[i]);
      n_checks++;
      if ({bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky} !== {v[i].eq, ~v[i].eq, v[i].eill, v[i].estk}) begin
        n_fail++;
        $display("FAIL sat[%0d] got q=%b qb=%b ill=%b stk=%b exp q=%b qb=%b ill=%b stk=%b", i,
                 bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky, v[i].eq, ~v[i].eq, v[i].eill, v[i].estk);
      end
`ifdef XFF_ILLEGAL_CNT_EN
      n_checks++;
      if (bus.illegal_cnt !== v[i].ecnt) begin
        n_fail++;
        $display("FAIL sat_cnt8[%0d] got %0d exp %0d", i, bus.illegal_cnt, v[i].ecnt);
      end
      n_checks++;
      if (sat_bus.illegal_cnt !== ((v[i].ecnt > 8'd3) ? 2'd3 : v[i].ecnt[1:0])) begin
        n_fail++;
        $display("FAIL sat_cnt2[%0d] got %0d exp %0d", i, sat_bus.illegal_cnt,
                 (v[i].ecnt > 8'd3) ? 2'd3 : v[i].ecnt[1:0]);
      end
`endif
    end
  endtask

  task automatic test_reset_midop();
    // Starts from q=0000, sticky=1, cnt=5.
    vec_t v[5] = '{
      '{1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 8'd5},
      '{1'b1, 1'b1, 2'd3, 4'h5, 4'h0, 1'b0, 4'hA, 1'b0, 1'b1, 8'd5},
      '{1'b0, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0}
    };
    foreach (v[i]) begin
      drive(v[i]);
      n_checks++;
      if ({bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky} !== {v[i].eq, ~v[i].eq, v[i].eill, v[i].estk}) begin
        n_fail++;
        $display("FAIL midop[%0d] got q=%b qb=%b ill=%b stk=%b exp q=%b qb=%b ill=%b stk=%b", i,
                 bus.q, bus.q_bar, bus.illegal, bus.illegal_sticky, v[i].eq, ~v[i].eq, v[i].eill, v[i].estk);
      end
`ifdef XFF_ILLEGAL_CNT_EN
      n_checks++;
      if (bus.illegal_cnt !== v[i].ecnt) begin
        n_fail++;
        $display("FAIL midop_cnt[%0d] got %0d exp %0d", i, bus.illegal_cnt, v[i].ecnt);
      end
`endif
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = XFF_SR;
    bus.a        = '0;
    bus.b        = '0;
    bus.clr_flag = 1'b0;
    #1;
    test_reset();
    test_modes();
    test_flags();
    test_saturation();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_xff_using_t
`default_nettype wire
